// File: rtl/ebus_diag_responder.sv
// ============================================================================
// Module   : ebus_diag_responder
// Purpose  : EBUS diagnostic function responder with read drive window and
//            burst/single-step clock engine. Optional scratch register at
//            index 7 is enabled by defining EBUS_DIAG_SCRATCH_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ebus_diag_responder #(
  parameter logic [2:0] SEL       = 3'd0,
  parameter int         READ_HOLD = 4
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic        diagStrobe,
  input  logic [0:6]  ds,
  input  logic [0:35] ebusDataIn,
  output logic [0:35] ebusDataOut,
  output logic        ebusDriving,
  output logic [0:35] ctrlOut,
  output logic        runEnable,
  output logic        stepPulse
);

  localparam logic [3:0] c_HOLD_INIT = 4'(READ_HOLD);

  logic [0:35] r_ctrl;
  logic        r_runEnable;
  logic        r_stepPulse;
  logic [0:9]  r_burstCount;
  logic        r_done;
  logic [3:0]  r_holdCnt;
  logic [0:35] r_dataOut;

  logic        w_sel;
  logic        w_read;
  logic        w_write;
  logic [2:0]  w_idx;
  logic        w_loadBurst;
  logic        w_clear;
  logic        w_doneSet;
  logic [0:35] w_readData;

  assign w_sel       = diagStrobe && (ds[1:3] == SEL);
  assign w_read      = w_sel && ds[0];
  assign w_write     = w_sel && !ds[0];
  assign w_idx       = ds[4:6];
  assign w_loadBurst = w_write && (w_idx == 3'd1);
  assign w_clear     = w_write && (w_idx == 3'd3);
  // Only a genuine decrement from 1 marks completion; load/clear never do.
  assign w_doneSet   = !w_loadBurst && !w_clear && (r_burstCount == 10'd1);

`ifdef EBUS_DIAG_SCRATCH_EN
  logic [0:35] r_scratch;

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      r_scratch <= '0;
    end else if (w_write && (w_idx == 3'd7)) begin
      r_scratch <= ebusDataIn;
    end
  end
`endif

  always_comb begin
    w_readData = '0;
    case (w_idx)
      3'd0: w_readData = r_ctrl;
      3'd1: w_readData[26:35] = r_burstCount;
      3'd2: begin
        w_readData[35] = r_runEnable;
        w_readData[34] = (r_burstCount != 10'd0);
        w_readData[33] = r_done;
      end
`ifdef EBUS_DIAG_SCRATCH_EN
      3'd7: w_readData = r_scratch;
`endif
      default: w_readData = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      r_ctrl       <= '0;
      r_runEnable  <= 1'b0;
      r_stepPulse  <= 1'b0;
      r_burstCount <= '0;
      r_done       <= 1'b0;
    end else begin
      if (w_write && (w_idx == 3'd0)) begin
        r_ctrl <= ebusDataIn;
      end

      if (w_write && (w_idx == 3'd2)) begin
        r_runEnable <= ebusDataIn[35];
      end else if (w_clear) begin
        r_runEnable <= 1'b0;
      end

      if (w_loadBurst) begin
        r_burstCount <= ebusDataIn[26:35];
        r_stepPulse  <= r_runEnable;
      end else if (w_clear) begin
        r_burstCount <= '0;
        r_stepPulse  <= 1'b0;
      end else if (r_burstCount != 10'd0) begin
        r_burstCount <= r_burstCount - 10'd1;
        r_stepPulse  <= 1'b1;
      end else begin
        r_stepPulse  <= r_runEnable;
      end

      // Set has priority over the status-read clear.
      if (w_doneSet) begin
        r_done <= 1'b1;
      end else if (w_read && (w_idx == 3'd2)) begin
        r_done <= 1'b0;
      end
    end
  end

  // Drive window: a selected read (re)opens it, any other strobe drops it.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      r_holdCnt <= '0;
      r_dataOut <= '0;
    end else if (w_read) begin
      r_holdCnt <= c_HOLD_INIT;
      r_dataOut <= w_readData;
    end else if (diagStrobe) begin
      r_holdCnt <= '0;
      r_dataOut <= '0;
    end else if (r_holdCnt != 4'd0) begin
      r_holdCnt <= r_holdCnt - 4'd1;
    end
  end

  assign ebusDriving = (r_holdCnt != 4'd0);
  assign ebusDataOut = ebusDriving ? r_dataOut : '0;
  assign ctrlOut     = r_ctrl;
  assign runEnable   = r_runEnable;
  assign stepPulse   = r_stepPulse;

endmodule

`default_nettype wire

// File: doc/ebus_diag_responder.md
# ebus_diag_responder

Board-side responder for EBUS diagnostic functions issued by the front-end DTE. Decodes the diagnostic select lines on each strobe, executes writes into local control state and answers reads by driving the EBUS data lines for a bounded window. Owns a burst-step engine so the front end can single-step or burst a board's clock domain.

## Interface
Parameters:
- `SEL`, 3'd0: board select; a function is ours only when `ds[1:3] == SEL`.
- `READ_HOLD`, 4: cycles `ebusDriving` stays asserted after a read strobe (1..15).

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `CROBAR`  in  1  reset; synchronous, active-high.
- `diagStrobe`  in  1  one-cycle function strobe; every cycle it is high is one function.
- `ds`  in  [0:6]  function select: `ds[0]` 1=read, 0=write/control; `ds[1:3]` board; `ds[4:6]` index.
- `ebusDataIn`  in  [0:35]  EBUS data as driven by the DTE (write payload).
- `ebusDataOut`  out  [0:35]  read response data.
- `ebusDriving`  out  1  responder is driving EBUS data.
- `ctrlOut`  out  [0:35]  control register.
- `runEnable`  out  1  free-run enable.
- `stepPulse`  out  1  one-cycle step pulse, registered.

## Operation
- Selected = `diagStrobe & ds[1:3]==SEL`. Unselected strobes execute nothing.
- Writes (`ds[0]=0`), by `ds[4:6]`:
  - 0: `ctrlOut <= ebusDataIn`.
  - 1: `burstCount[0:9] <= ebusDataIn[26:35]`.
  - 2: `runEnable <= ebusDataIn[35]`.
  - 3: clear: `burstCount<=0`, `runEnable<=0`; `ctrlOut`, `done` unchanged.
  - 7: scratch write (see Configuration). 4-6: no-op.
- Reads (`ds[0]=1`), value snapshotted from state before the strobe edge:
  - 0: `ctrlOut`. 1: `{26'b0, burstCount}`. 2: status: bit35 `runEnable`, bit34 `burstCount!=0`, bit33 `done`, others 0. 7: scratch. 3-6: 0.
- Step engine, each cycle not loading burst: if `burstCount!=0`: `stepPulse<=1`, `burstCount<=burstCount-1`; else `stepPulse<=runEnable`.
- Burst load in the same cycle overrides decrement; reload while bursting restarts from the new value.
- `done` (sticky): set when `burstCount` goes 1->0; cleared by a selected read of index 2. Set and clear in the same cycle: set wins; the read returns the pre-edge value.
- Drive window: selected read at cycle t -> `ebusDriving=1`, `ebusDataOut`=snapshot for t+1..t+READ_HOLD, then 0. Another selected read restarts window with new data. Any other strobe (write, or unselected anything) during the window drops `ebusDriving` next cycle to avoid contention.
- `ebusDataOut` is 0 whenever `ebusDriving=0`.

## Timing
- Reset (`CROBAR=1` at edge): `ctrlOut=0`, `runEnable=0`, `stepPulse=0`, `ebusDriving=0`, `ebusDataOut=0`, `burstCount=0`, `done=0`, scratch=0. Reset mid-burst or mid-window aborts immediately; strobes during reset ignored.
- Write latency: register visible cycle after strobe.
- Burst of N at strobe t: `stepPulse` high t+2..t+N+1 (exactly N pulses), `done` visible from t+N+1. N=0: no pulses, `done` unchanged.
- With `runEnable=1` and count 0, `stepPulse` high every cycle; burst pulses are indistinguishable but counted.
- Read latency: one cycle to first driven cycle.

## Configuration
- `EBUS_DIAG_SCRATCH_EN` defined: 36-bit scratch register at index 7, write loads `ebusDataIn`, read returns it.
- Undefined: no scratch storage; index-7 write is a no-op, index-7 read drives 0 for the normal window.

## Test plan
- Reset, then write idx0 `36'o123456701234` with SEL match -> `ctrlOut` equals it next cycle; read idx0 -> `ebusDriving` high 4 cycles with same data, then 0.
- Burst load 5 at t -> `stepPulse` high t+2..t+6, status read afterwards returns bit34=0 bit33=1; second status read returns bit33=0.
- Burst 100, at count 40 write idx3 -> pulses stop next cycle, status bit34=0, `done`=0.
- Read idx1 then write idx0 on cycle t+2 -> `ebusDriving` 0 from t+3; read with `ds[1:3]!=SEL` -> no drive, no state change.
- `runEnable=1` via idx2 data bit35=1 -> continuous `stepPulse`; assert `CROBAR` mid-run -> all outputs 0 next cycle.
- Scratch write/read `36'o777777000000` -> returns it with `EBUS_DIAG_SCRATCH_EN`, 0 without.
